// File: rtl/t_seq_counter.sv
// T-flip-flop sequence counter: binary up/down, Gray up, Johnson.
// State toggles by q ^ tog each edge; tog is the combinational diff to next.
module t_seq_counter #(
  parameter int WIDTH = 4,
  parameter int MAX   = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] nq,
  output logic [WIDTH-1:0] tog,
  output logic             tc
);

  typedef enum logic [1:0] {
    M_UP   = 2'b00,
    M_DN   = 2'b01,
    M_GRAY = 2'b10,
    M_JOHN = 2'b11
  } mode_e;

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] MSB  =
    {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] binc;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] nxt;
  logic             wrap;

  function automatic logic [WIDTH-1:0] g2b(
    input logic [WIDTH-1:0] g
  );
    logic [WIDTH-1:0] b;
    b = '0;
    for (int i = 0; i < WIDTH; i++)
      b[i] = ^(g >> i);
    return b;
  endfunction

  always_comb begin
    cnt  = q;
    wrap = 1'b0;
    binc = g2b(q) + WIDTH'(1);
    case (mode_e'(mode))
      M_UP: begin
        wrap = (q >= MAXV);
        cnt  = wrap ? '0 : q + WIDTH'(1);
      end
      M_DN: begin
        wrap = (q == '0) || (q > MAXV);
        cnt  = wrap ? MAXV : q - WIDTH'(1);
      end
      M_GRAY: begin
        wrap = (q == MSB);
        cnt  = binc ^ (binc >> 1);
      end
      default: begin
        wrap = (q == MSB);
        cnt  = {q[WIDTH-2:0], ~q[WIDTH-1]};
      end
    endcase
  end

  always_comb begin
    nxt = q;
    unique case (1'b1)
      load:        nxt = d;
      (en & ~load): nxt = cnt;
      default:     nxt = q;
    endcase
  end

  // Gated by rst so the outputs settle to idle without a clock.
  assign tog = rst ? '0 : (q ^ nxt);
  assign tc  = ~rst & en & ~load & wrap;
  assign nq  = ~q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= '0;
    else     q <= q ^ tog;
  end

endmodule
